intm_rs_multi: RTL and testbench

- Parametrised, age-ordered, compressing reservation station for the integer multiply/divide pipe; sits between dispatch and the md functional unit.
- Accepts up to DISP_W uops per cycle.
- Snoops CDB_W CDB ports to wake up source operands.
- Issues the oldest ready entry to the FU over a valid/ready handshake.
- Adds flush, an occupancy count and sparse dispatch lanes.

---
 rtl/intm_rs_multi_if.sv | 40 ++++
 rtl/intm_rs_multi.sv | 170 +++++++++++++++++
 tb/tb_intm_rs_multi.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/intm_rs_multi_if.sv
// Dispatch, CDB, issue and status bundle for the integer mul/div reservation station.
// master = dispatch/CDB/FU side that drives the RS; slave = the reservation station.
interface intm_rs_multi_if #(
  parameter int DEPTH     = 8,
  parameter int DISP_W    = 2,
  parameter int CDB_W     = 2,
  parameter int PRF_IDX_W = 6,
  parameter int PAYLOAD_W = 32
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                          flush;
  logic [DISP_W-1:0]             disp_valid;
  logic                          disp_ready;
  logic [DISP_W*PRF_IDX_W-1:0]   disp_rs1_phy;
  logic [DISP_W*PRF_IDX_W-1:0]   disp_rs2_phy;
  logic [DISP_W-1:0]             disp_rs1_rdy;
  logic [DISP_W-1:0]             disp_rs2_rdy;
  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload;
  logic [CDB_W-1:0]              cdb_valid;
  logic [CDB_W*PRF_IDX_W-1:0]    cdb_rd_phy;
  logic                          iss_valid;
  logic                          iss_ready;
  logic [PRF_IDX_W-1:0]          iss_rs1_phy;
  logic [PRF_IDX_W-1:0]          iss_rs2_phy;
  logic [PAYLOAD_W-1:0]          iss_payload;
  logic [OCC_W-1:0]              occupancy;

  modport master (
    output flush, disp_valid, disp_rs1_phy, disp_rs2_phy, disp_rs1_rdy, disp_rs2_rdy,
           disp_payload, cdb_valid, cdb_rd_phy, iss_ready,
    input  disp_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_payload, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_rs1_phy, disp_rs2_phy, disp_rs1_rdy, disp_rs2_rdy,
           disp_payload, cdb_valid, cdb_rd_phy, iss_ready,
    output disp_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_payload, occupancy
  );
endinterface

// File: rtl/intm_rs_multi.sv
// Age-ordered, compressing reservation station for the integer mul/div pipe.
// Define INTM_RS_WAKEUP_BYPASS_EN to let issue select see same-cycle CDB wakeups.
module intm_rs_multi #(
  parameter int DEPTH     = 8,
  parameter int DISP_W    = 2,
  parameter int CDB_W     = 2,
  parameter int PRF_IDX_W = 6,
  parameter int PAYLOAD_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  intm_rs_multi_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DISP_W + 1);

  typedef logic [PRF_IDX_W-1:0] phy_t;

  typedef struct packed {
    logic                 valid;
    phy_t                 rs1_phy;
    logic                 rs1_rdy;
    phy_t                 rs2_phy;
    logic                 rs2_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  entry_t           r_ent [DEPTH];
  logic [OCC_W-1:0] r_occ;

  entry_t           w_woken    [DEPTH];
  entry_t           w_ent_nxt  [DEPTH];
  entry_t           w_lane_ent [DISP_W];
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;
  logic [DEPTH-1:0] w_sel_rdy;
  logic             w_sel_found;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_iss_valid;
  logic             w_pop;
  logic             w_disp_ready;
  logic [OCC_W-1:0] w_base;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [CNT_W-1:0] w_push_cnt;

  function automatic logic f_cdb_hit(
    input phy_t                       phy,
    input logic [CDB_W-1:0]           cv,
    input logic [CDB_W*PRF_IDX_W-1:0] cp
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_W; k++) begin
      if (cv[k] && (cp[k*PRF_IDX_W +: PRF_IDX_W] == phy)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Stored entries with this cycle's CDB wakeups applied; feeds both storage and bypass select.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1[i]          = f_cdb_hit(r_ent[i].rs1_phy, bus.cdb_valid, bus.cdb_rd_phy);
      w_hit2[i]          = f_cdb_hit(r_ent[i].rs2_phy, bus.cdb_valid, bus.cdb_rd_phy);
      w_woken[i]         = r_ent[i];
      w_woken[i].rs1_rdy = r_ent[i].rs1_rdy | w_hit1[i];
      w_woken[i].rs2_rdy = r_ent[i].rs2_rdy | w_hit2[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef INTM_RS_WAKEUP_BYPASS_EN
      w_sel_rdy[i] = r_ent[i].valid & w_woken[i].rs1_rdy & w_woken[i].rs2_rdy;
`else
      w_sel_rdy[i] = r_ent[i].valid & r_ent[i].rs1_rdy & r_ent[i].rs2_rdy;
`endif
    end
  end

  // Lowest index wins: it is the oldest ready entry.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_sel_rdy[i]) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDX_W'(i);
      end
    end
  end

  assign w_iss_valid  = w_sel_found & ~bus.flush;
  assign w_pop        = w_iss_valid & bus.iss_ready;
  assign w_disp_ready = (r_occ <= OCC_W'(DEPTH - DISP_W));

  always_comb begin
    bus.iss_rs1_phy = '0;
    bus.iss_rs2_phy = '0;
    bus.iss_payload = '0;
    if (w_iss_valid) begin
      bus.iss_rs1_phy = r_ent[w_sel_idx].rs1_phy;
      bus.iss_rs2_phy = r_ent[w_sel_idx].rs2_phy;
      bus.iss_payload = r_ent[w_sel_idx].payload;
    end
  end

  assign bus.iss_valid  = w_iss_valid;
  assign bus.disp_ready = w_disp_ready;
  assign bus.occupancy  = r_occ;

  // Incoming uops capture a same-cycle CDB broadcast so the wakeup is not lost.
  always_comb begin
    for (int l = 0; l < DISP_W; l++) begin
      w_lane_ent[l]         = '0;
      w_lane_ent[l].valid   = 1'b1;
      w_lane_ent[l].rs1_phy = bus.disp_rs1_phy[l*PRF_IDX_W +: PRF_IDX_W];
      w_lane_ent[l].rs2_phy = bus.disp_rs2_phy[l*PRF_IDX_W +: PRF_IDX_W];
      w_lane_ent[l].rs1_rdy = bus.disp_rs1_rdy[l] |
                              f_cdb_hit(w_lane_ent[l].rs1_phy, bus.cdb_valid, bus.cdb_rd_phy);
      w_lane_ent[l].rs2_rdy = bus.disp_rs2_rdy[l] |
                              f_cdb_hit(w_lane_ent[l].rs2_phy, bus.cdb_valid, bus.cdb_rd_phy);
      w_lane_ent[l].payload = bus.disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign w_base = r_occ - OCC_W'(w_pop);

  // Compress above the popped slot, then append compacted dispatch lanes above the new top.
  always_comb begin
    int slot;
    slot       = 0;
    w_push_cnt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_ent_nxt[j] = w_woken[j];
    end
    for (int j = 0; j < DEPTH - 1; j++) begin
      if (w_pop && (int'(w_sel_idx) <= j)) w_ent_nxt[j] = w_woken[j+1];
    end
    if (w_pop) w_ent_nxt[DEPTH-1] = '0;
    for (int l = 0; l < DISP_W; l++) begin
      if (w_disp_ready && bus.disp_valid[l]) begin
        slot = int'(w_base) + int'(w_push_cnt);
        if (slot < DEPTH) w_ent_nxt[IDX_W'(slot)] = w_lane_ent[l];
        w_push_cnt = w_push_cnt + CNT_W'(1);
      end
    end
  end

  assign w_occ_nxt = w_base + OCC_W'(w_push_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else if (bus.flush) begin
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i].valid <= 1'b0;
      end
    end else begin
      r_occ <= w_occ_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= w_ent_nxt[i];
      end
    end
  end
endmodule

// File: tb/tb_intm_rs_multi.sv
// Self-checking bench for intm_rs_multi: directed scenarios plus a randomized run
// against an age-ordered queue model of the reservation station.
module tb_intm_rs_multi;
  localparam int DEPTH     = 8;
  localparam int DISP_W    = 2;
  localparam int CDB_W     = 2;
  localparam int PRF_IDX_W = 6;
  localparam int PAYLOAD_W = 32;
  localparam int OCC_W     = $clog2(DEPTH + 1);
`ifdef INTM_RS_WAKEUP_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  intm_rs_multi_if #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CDB_W(CDB_W),
                     .PRF_IDX_W(PRF_IDX_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

  intm_rs_multi #(.DEPTH(DEPTH), .DISP_W(DISP_W), .CDB_W(CDB_W),
                  .PRF_IDX_W(PRF_IDX_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          p1;
    bit          r1;
    int          p2;
    bit          r2;
    int unsigned pl;
  } m_ent_t;

  m_ent_t mq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.flush        = 1'b0;
    bus.disp_valid   = '0;
    bus.disp_rs1_phy = '0;
    bus.disp_rs2_phy = '0;
    bus.disp_rs1_rdy = '0;
    bus.disp_rs2_rdy = '0;
    bus.disp_payload = '0;
    bus.cdb_valid    = '0;
    bus.cdb_rd_phy   = '0;
    bus.iss_ready    = 1'b0;
  endtask

  task automatic set_lane(input int l, input int p1, input bit r1, input int p2, input bit r2,
                          input logic [31:0] pl);
    bus.disp_valid[l]                              = 1'b1;
    bus.disp_rs1_phy[l*PRF_IDX_W +: PRF_IDX_W]     = PRF_IDX_W'(p1);
    bus.disp_rs2_phy[l*PRF_IDX_W +: PRF_IDX_W]     = PRF_IDX_W'(p2);
    bus.disp_rs1_rdy[l]                            = r1;
    bus.disp_rs2_rdy[l]                            = r2;
    bus.disp_payload[l*PAYLOAD_W +: PAYLOAD_W]     = pl;
  endtask

  task automatic set_cdb(input int k, input int phy);
    bus.cdb_valid[k]                          = 1'b1;
    bus.cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W]  = PRF_IDX_W'(phy);
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mq.delete();
  endtask

  function automatic bit m_hit(input int phy);
    for (int k = 0; k < CDB_W; k++) begin
      if (bus.cdb_valid[k] && (int'(bus.cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W]) == phy)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.occupancy !== OCC_W'(0)) begin n_err++; $display("FAIL reset_occ: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.iss_valid !== 1'b0) begin n_err++; $display("FAIL reset_iss_valid: got %b want 0", bus.iss_valid); end
    n_cmp++; if (bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_disp_ready: got %b want 1", bus.disp_ready); end
    n_cmp++; if (bus.iss_payload !== 32'h0) begin n_err++; $display("FAIL reset_payload: got %h want 0", bus.iss_payload); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      clr_in();
      set_lane(0, 1, 1'b1, 2, 1'b1, 32'h100 + 2*c);
      set_lane(1, 3, 1'b1, 4, 1'b1, 32'h101 + 2*c);
      tick();
      n_cmp++; if (bus.occupancy !== OCC_W'(2*(c+1))) begin n_err++; $display("FAIL fill_occ[%0d]: got %0d want %0d", c, bus.occupancy, 2*(c+1)); end
    end
    clr_in();
    #1;
    n_cmp++; if (bus.disp_ready !== 1'b0) begin n_err++; $display("FAIL fill_disp_ready_full: got %b want 0", bus.disp_ready); end
    set_lane(0, 1, 1'b1, 2, 1'b1, 32'h1FF);
    set_lane(1, 1, 1'b1, 2, 1'b1, 32'h1FE);
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.occupancy !== OCC_W'(8)) begin n_err++; $display("FAIL fill_5th_ignored_occ: got %0d want 8", bus.occupancy); end
    bus.iss_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'h100 + i) begin n_err++; $display("FAIL fill_drain[%0d]: got v=%b pl=%h want v=1 pl=%h", i, bus.iss_valid, bus.iss_payload, 32'h100 + i); end
      tick();
    end
    n_cmp++; if (bus.iss_valid !== 1'b0 || bus.occupancy !== OCC_W'(0)) begin n_err++; $display("FAIL fill_drained: got v=%b occ=%0d want v=0 occ=0", bus.iss_valid, bus.occupancy); end
  endtask

  task automatic test_oldest_first();
    do_reset();
    set_lane(0, 10, 1'b1, 11, 1'b1, 32'h200);
    set_lane(1, 40, 1'b0, 12, 1'b1, 32'h201);
    tick();
    clr_in();
    set_lane(0, 13, 1'b1, 14, 1'b1, 32'h202);
    set_lane(1, 15, 1'b1, 41, 1'b0, 32'h203);
    tick();
    clr_in();
    bus.iss_ready = 1'b1;
    #1;
    n_cmp++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'h200 || bus.occupancy !== OCC_W'(4)) begin n_err++; $display("FAIL oldest_first0: got v=%b pl=%h occ=%0d want v=1 pl=200 occ=4", bus.iss_valid, bus.iss_payload, bus.occupancy); end
    tick();
    n_cmp++; if (bus.iss_payload !== 32'h202 || bus.iss_rs1_phy !== 6'd13 || bus.iss_rs2_phy !== 6'd14 || bus.occupancy !== OCC_W'(3)) begin n_err++; $display("FAIL oldest_first1: got pl=%h rs1=%0d rs2=%0d occ=%0d want pl=202 rs1=13 rs2=14 occ=3", bus.iss_payload, bus.iss_rs1_phy, bus.iss_rs2_phy, bus.occupancy); end
    tick();
    n_cmp++; if (bus.iss_valid !== 1'b0 || bus.occupancy !== OCC_W'(2)) begin n_err++; $display("FAIL oldest_first2: got v=%b occ=%0d want v=0 occ=2", bus.iss_valid, bus.occupancy); end
  endtask

  task automatic test_cdb_wakeup();
    do_reset();
    set_lane(0, 17, 1'b0, 3, 1'b1, 32'h300);
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.iss_valid !== 1'b0 || bus.occupancy !== OCC_W'(1)) begin n_err++; $display("FAIL wake_wait: got v=%b occ=%0d want v=0 occ=1", bus.iss_valid, bus.occupancy); end
    bus.cdb_rd_phy[0 +: PRF_IDX_W] = 6'd17;
    set_cdb(1, 17);
    #1;
    n_cmp++; if (bus.iss_valid !== BYPASS) begin n_err++; $display("FAIL wake_same_cycle: got %b want %b", bus.iss_valid, BYPASS); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'h300 || bus.iss_rs1_phy !== 6'd17) begin n_err++; $display("FAIL wake_next_cycle: got v=%b pl=%h rs1=%0d want v=1 pl=300 rs1=17", bus.iss_valid, bus.iss_payload, bus.iss_rs1_phy); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] order [6];
    order = '{32'h400, 32'h402, 32'h403, 32'h404, 32'h405, 32'h407};
    do_reset();
    set_lane(0, 50, 1'b0, 1, 1'b1, 32'h400);
    set_lane(1, 2, 1'b1, 3, 1'b1, 32'h401);
    tick();
    clr_in();
    set_lane(0, 51, 1'b0, 4, 1'b1, 32'h402);
    set_lane(1, 5, 1'b1, 52, 1'b0, 32'h403);
    tick();
    clr_in();
    set_lane(0, 53, 1'b0, 6, 1'b1, 32'h404);
    set_lane(1, 7, 1'b1, 54, 1'b0, 32'h405);
    tick();
    clr_in();
    bus.iss_ready = 1'b1;
    set_lane(0, 30, 1'b0, 8, 1'b1, 32'h406);
    set_lane(1, 31, 1'b0, 9, 1'b1, 32'h407);
    set_cdb(0, 30);
    #1;
    n_cmp++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'h401 || bus.disp_ready !== 1'b1 || bus.occupancy !== OCC_W'(6)) begin n_err++; $display("FAIL simul_pre: got v=%b pl=%h dr=%b occ=%0d want v=1 pl=401 dr=1 occ=6", bus.iss_valid, bus.iss_payload, bus.disp_ready, bus.occupancy); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.occupancy !== OCC_W'(7)) begin n_err++; $display("FAIL simul_occ: got %0d want 7", bus.occupancy); end
    bus.iss_ready = 1'b1;
    #1;
    n_cmp++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'h406) begin n_err++; $display("FAIL simul_captured_ready: got v=%b pl=%h want v=1 pl=406", bus.iss_valid, bus.iss_payload); end
    tick();
    clr_in();
    set_cdb(0, 50); set_cdb(1, 51);
    tick();
    clr_in();
    set_cdb(0, 52); set_cdb(1, 53);
    tick();
    clr_in();
    set_cdb(0, 54); set_cdb(1, 31);
    tick();
    clr_in();
    bus.iss_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== order[i]) begin n_err++; $display("FAIL simul_order[%0d]: got v=%b pl=%h want v=1 pl=%h", i, bus.iss_valid, bus.iss_payload, order[i]); end
      tick();
    end
    n_cmp++; if (bus.occupancy !== OCC_W'(0)) begin n_err++; $display("FAIL simul_empty: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_sparse();
    logic [31:0] order [4];
    order = '{32'h500, 32'h501, 32'h502, 32'h503};
    do_reset();
    set_lane(0, 20, 1'b0, 1, 1'b1, 32'h500);
    set_lane(1, 21, 1'b0, 1, 1'b1, 32'h501);
    tick();
    clr_in();
    set_lane(0, 22, 1'b0, 1, 1'b1, 32'h502);
    tick();
    clr_in();
    set_lane(0, 1, 1'b1, 1, 1'b1, 32'hDEAD);
    bus.disp_valid[0] = 1'b0;
    set_lane(1, 2, 1'b1, 3, 1'b1, 32'h503);
    #1;
    n_cmp++; if (bus.occupancy !== OCC_W'(3) || bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL sparse_pre: got occ=%0d dr=%b want occ=3 dr=1", bus.occupancy, bus.disp_ready); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.occupancy !== OCC_W'(4) || bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'h503) begin n_err++; $display("FAIL sparse_post: got occ=%0d v=%b pl=%h want occ=4 v=1 pl=503", bus.occupancy, bus.iss_valid, bus.iss_payload); end
    set_cdb(0, 20); set_cdb(1, 21);
    tick();
    clr_in();
    set_cdb(0, 22);
    tick();
    clr_in();
    bus.iss_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== order[i]) begin n_err++; $display("FAIL sparse_order[%0d]: got v=%b pl=%h want v=1 pl=%h", i, bus.iss_valid, bus.iss_payload, order[i]); end
      tick();
    end
    n_cmp++; if (bus.iss_valid !== 1'b0 || bus.occupancy !== OCC_W'(0)) begin n_err++; $display("FAIL sparse_empty: got v=%b occ=%0d want v=0 occ=0", bus.iss_valid, bus.occupancy); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      clr_in();
      set_lane(0, 1, 1'b1, 2, 1'b1, 32'h600 + 2*c);
      if (c < 2) set_lane(1, 1, 1'b1, 2, 1'b1, 32'h601 + 2*c);
      tick();
    end
    clr_in();
    #1;
    n_cmp++; if (bus.occupancy !== OCC_W'(5)) begin n_err++; $display("FAIL flush_pre_occ: got %0d want 5", bus.occupancy); end
    bus.flush = 1'b1;
    bus.iss_ready = 1'b1;
    set_lane(0, 1, 1'b1, 2, 1'b1, 32'h6A0);
    set_lane(1, 1, 1'b1, 2, 1'b1, 32'h6A1);
    #1;
    n_cmp++; if (bus.iss_valid !== 1'b0) begin n_err++; $display("FAIL flush_iss_valid_during: got %b want 0", bus.iss_valid); end
    tick();
    clr_in();
    #1;
    n_cmp++; if (bus.occupancy !== OCC_W'(0) || bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin n_err++; $display("FAIL flush_after: got occ=%0d v=%b dr=%b want occ=0 v=0 dr=1", bus.occupancy, bus.iss_valid, bus.disp_ready); end
    tick();
    n_cmp++; if (bus.iss_valid !== 1'b0 || bus.iss_payload !== 32'h0) begin n_err++; $display("FAIL flush_pushes_dropped: got v=%b pl=%h want v=0 pl=0", bus.iss_valid, bus.iss_payload); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_lane(0, 1, 1'b1, 2, 1'b1, 32'h700);
    set_lane(1, 1, 1'b1, 2, 1'b1, 32'h701);
    tick();
    clr_in();
    set_lane(0, 1, 1'b1, 2, 1'b1, 32'h702);
    tick();
    clr_in();
    bus.iss_ready = 1'b1;
    #1;
    n_cmp++; if (bus.iss_valid !== 1'b1 || bus.iss_payload !== 32'h700) begin n_err++; $display("FAIL areset_pre: got v=%b pl=%h want v=1 pl=700", bus.iss_valid, bus.iss_payload); end
    tick();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (bus.occupancy !== OCC_W'(0) || bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1 || bus.iss_payload !== 32'h0) begin n_err++; $display("FAIL areset_immediate: got occ=%0d v=%b dr=%b pl=%h want occ=0 v=0 dr=1 pl=0", bus.occupancy, bus.iss_valid, bus.disp_ready, bus.iss_payload); end
    #1;
    rst_n = 1'b1;
    clr_in();
    tick();
  endtask

  task automatic test_random();
    int unsigned uid;
    int          sel;
    bit          exp_dr;
    bit          r1;
    bit          r2;
    m_ent_t      e;
    uid = 32'h1000;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      clr_in();
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.iss_ready = ($urandom_range(0, 2) != 0);
      for (int l = 0; l < DISP_W; l++) begin
        if ($urandom_range(0, 1) == 1) begin
          set_lane(l, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 15), $urandom_range(0, 3) != 0, uid);
          uid++;
        end
      end
      for (int k = 0; k < CDB_W; k++) begin
        if ($urandom_range(0, 1) == 1) set_cdb(k, $urandom_range(0, 15));
      end
      #1;
      exp_dr = ((DEPTH - mq.size()) >= DISP_W);
      sel = -1;
      if (!bus.flush) begin
        for (int i = 0; i < mq.size(); i++) begin
          r1 = mq[i].r1 || (BYPASS && m_hit(mq[i].p1));
          r2 = mq[i].r2 || (BYPASS && m_hit(mq[i].p2));
          if (sel < 0 && r1 && r2) sel = i;
        end
      end
      n_cmp++; if (bus.occupancy !== OCC_W'(mq.size())) begin n_err++; $display("FAIL rand_occ[%0d]: got %0d want %0d", cyc, bus.occupancy, mq.size()); end
      n_cmp++; if (bus.disp_ready !== exp_dr) begin n_err++; $display("FAIL rand_disp_ready[%0d]: got %b want %b", cyc, bus.disp_ready, exp_dr); end
      n_cmp++; if (bus.iss_valid !== (sel >= 0)) begin n_err++; $display("FAIL rand_iss_valid[%0d]: got %b want %b", cyc, bus.iss_valid, sel >= 0); end
      if (sel >= 0) begin
        n_cmp++; if (bus.iss_payload !== mq[sel].pl || bus.iss_rs1_phy !== PRF_IDX_W'(mq[sel].p1) || bus.iss_rs2_phy !== PRF_IDX_W'(mq[sel].p2)) begin n_err++; $display("FAIL rand_iss_data[%0d]: got pl=%h rs1=%0d rs2=%0d want pl=%h rs1=%0d rs2=%0d", cyc, bus.iss_payload, bus.iss_rs1_phy, bus.iss_rs2_phy, mq[sel].pl, mq[sel].p1, mq[sel].p2); end
      end else begin
        n_cmp++; if (bus.iss_payload !== 32'h0) begin n_err++; $display("FAIL rand_iss_idle[%0d]: got pl=%h want 0", cyc, bus.iss_payload); end
      end
      if (bus.flush) begin
        mq.delete();
      end else begin
        for (int i = 0; i < mq.size(); i++) begin
          if (m_hit(mq[i].p1)) mq[i].r1 = 1'b1;
          if (m_hit(mq[i].p2)) mq[i].r2 = 1'b1;
        end
        if (sel >= 0 && bus.iss_ready) mq.delete(sel);
        if (exp_dr) begin
          for (int l = 0; l < DISP_W; l++) begin
            if (bus.disp_valid[l]) begin
              e.p1 = int'(bus.disp_rs1_phy[l*PRF_IDX_W +: PRF_IDX_W]);
              e.p2 = int'(bus.disp_rs2_phy[l*PRF_IDX_W +: PRF_IDX_W]);
              e.r1 = bus.disp_rs1_rdy[l] || m_hit(e.p1);
              e.r2 = bus.disp_rs2_rdy[l] || m_hit(e.p2);
              e.pl = bus.disp_payload[l*PAYLOAD_W +: PAYLOAD_W];
              mq.push_back(e);
            end
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    test_reset();
    test_fill();
    test_oldest_first();
    test_cdb_wakeup();
    test_simultaneous();
    test_sparse();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
